// File: rtl/cipher_arbiter_if.sv
// Handshake bundle between the two requesters, the arbiter and the core.
//   a_* / b_* : requester beat in (vin/tin/din, rdy) and result out (vout/tout/dout)
//   c_*       : core stream-in (vin/tin/din) and core stream-out (vout/tout/dout)
// Modport slave is the arbiter's view; modport master is the environment's view.
interface cipher_arbiter_if;
  logic         a_vin;
  logic [1:0]   a_tin;
  logic [127:0] a_din;
  logic         a_rdy;
  logic         a_vout;
  logic         a_tout;
  logic [127:0] a_dout;

  logic         b_vin;
  logic [1:0]   b_tin;
  logic [127:0] b_din;
  logic         b_rdy;
  logic         b_vout;
  logic         b_tout;
  logic [127:0] b_dout;

  logic         c_vin;
  logic [1:0]   c_tin;
  logic [127:0] c_din;
  logic         c_vout;
  logic         c_tout;
  logic [127:0] c_dout;

  modport slave (
    input  a_vin, a_tin, a_din, b_vin, b_tin, b_din, c_vout, c_tout, c_dout,
    output a_rdy, a_vout, a_tout, a_dout, b_rdy, b_vout, b_tout, b_dout,
    output c_vin, c_tin, c_din
  );

  modport master (
    output a_vin, a_tin, a_din, b_vin, b_tin, b_din, c_vout, c_tout, c_dout,
    input  a_rdy, a_vout, a_tout, a_dout, b_rdy, b_vout, b_tout, b_dout,
    input  c_vin, c_tin, c_din
  );
endinterface

// File: rtl/cipher_arbiter.sv
// Two-requester round-robin front end for cipher_core.
// Shares the core stream-in port between requesters A and B, remembers the owner
// of every in-flight ENC/DEC beat in a 1-bit tag FIFO and steers each core result
// back to that owner. KEY/IV beats are held until the pipeline has drained.
// Ports:
//   clk          : clock, rising edge
//   rst_n        : synchronous active-low reset
//   crypto_ready : core keyed and ready; no grants while low
//   err          : sticky orphan-response flag (core result with no owner)
//   bus          : requester and core handshake bundle (cipher_arbiter_if.slave)
//
// state  | meaning
// PRIO_A | requester A wins when both are eligible
// PRIO_B | requester B wins when both are eligible
module cipher_arbiter #(
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             crypto_ready,
  output logic             err,
  cipher_arbiter_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

  typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_e;

  prio_e        prio_q, prio_d;
  logic [AW:0]  occ_q, occ_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic         tag_mem_q [DEPTH];

  logic         c_vin_q, c_vin_d;
  logic [1:0]   c_tin_q, c_tin_d;
  logic [127:0] c_din_q, c_din_d;
  logic         a_vout_q, a_vout_d;
  logic         a_tout_q, a_tout_d;
  logic [127:0] a_dout_q, a_dout_d;
  logic         b_vout_q, b_vout_d;
  logic         b_tout_q, b_tout_d;
  logic [127:0] b_dout_q, b_dout_d;
  logic         err_q, err_d;

  logic elig_a, elig_b;
  logic grant_a, grant_b;
  logic accept, push, pop, pop_tag, fifo_empty;
  logic [1:0]   sel_tin;
  logic [127:0] sel_din;

  assign fifo_empty = (occ_q == '0);

  // A KEY/IV beat only needs an empty FIFO: a grant to it is the only grant this
  // cycle, so no push can coincide with it.
  assign elig_a = rst_n & crypto_ready & bus.a_vin &
                  (bus.a_tin[1] ? fifo_empty : (occ_q < OCC_FULL));
  assign elig_b = rst_n & crypto_ready & bus.b_vin &
                  (bus.b_tin[1] ? fifo_empty : (occ_q < OCC_FULL));

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    prio_d  = prio_q;
    if (elig_a && (!elig_b || prio_q == PRIO_A)) begin
      grant_a = 1'b1;
    end else if (elig_b) begin
      grant_b = 1'b1;
    end
    if (grant_a) begin
      prio_d = PRIO_B;
    end else if (grant_b) begin
      prio_d = PRIO_A;
    end
  end

  assign bus.a_rdy = grant_a;
  assign bus.b_rdy = grant_b;

  assign accept  = grant_a | grant_b;
  assign sel_tin = grant_b ? bus.b_tin : bus.a_tin;
  assign sel_din = grant_b ? bus.b_din : bus.a_din;
  assign push    = accept & ~sel_tin[1];
  assign pop     = bus.c_vout & ~fifo_empty;
  assign pop_tag = tag_mem_q[rd_ptr_q];

  always_comb begin
    c_vin_d  = accept;
    c_tin_d  = c_tin_q;
    c_din_d  = c_din_q;
    if (accept) begin
      c_tin_d = sel_tin;
      c_din_d = sel_din;
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    occ_d    = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    a_vout_d = pop & ~pop_tag;
    b_vout_d = pop &  pop_tag;
    a_tout_d = a_vout_d & bus.c_tout;
    b_tout_d = b_vout_d & bus.c_tout;
    a_dout_d = a_vout_d ? bus.c_dout : '0;
    b_dout_d = b_vout_d ? bus.c_dout : '0;

    err_d    = err_q | (bus.c_vout & fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q   <= PRIO_A;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      c_vin_q  <= 1'b0;
      c_tin_q  <= '0;
      c_din_q  <= '0;
      a_vout_q <= 1'b0;
      a_tout_q <= 1'b0;
      a_dout_q <= '0;
      b_vout_q <= 1'b0;
      b_tout_q <= 1'b0;
      b_dout_q <= '0;
      err_q    <= 1'b0;
    end else begin
      prio_q   <= prio_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      c_vin_q  <= c_vin_d;
      c_tin_q  <= c_tin_d;
      c_din_q  <= c_din_d;
      a_vout_q <= a_vout_d;
      a_tout_q <= a_tout_d;
      a_dout_q <= a_dout_d;
      b_vout_q <= b_vout_d;
      b_tout_q <= b_tout_d;
      b_dout_q <= b_dout_d;
      err_q    <= err_d;
    end
  end

  // Tag storage needs no reset: entries are only read while occupancy says valid.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem_q[wr_ptr_q] <= grant_b;
    end
  end

  assign bus.c_vin  = c_vin_q;
  assign bus.c_tin  = c_tin_q;
  assign bus.c_din  = c_din_q;
  assign bus.a_vout = a_vout_q;
  assign bus.a_tout = a_tout_q;
  assign bus.a_dout = a_dout_q;
  assign bus.b_vout = b_vout_q;
  assign bus.b_tout = b_tout_q;
  assign bus.b_dout = b_dout_q;
  assign err        = err_q;

endmodule

// File: tb/tb_cipher_arbiter.sv
module tb_cipher_arbiter;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, crypto_ready, err;
  cipher_arbiter_if bus();

  cipher_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .crypto_ready(crypto_ready), .err(err), .bus(bus)
  );

  typedef struct packed {logic v; logic t; logic [127:0] d;} core_beat_t;
  typedef struct {bit cr; bit av; logic [1:0] at; bit bv; logic [1:0] bt; bit ea; bit eb;} vec_t;

  int checks = 0;
  int errors = 0;

  // drive values applied at the next step
  bit d_rst_n, d_cr, d_a_vin, d_b_vin;
  logic [1:0] d_a_tin, d_b_tin;
  logic [127:0] d_a_din, d_b_din;

  // core model: fixed-latency pipeline plus one-shot injection
  core_beat_t pipe[$];
  bit core_on;
  bit inj_v;
  logic inj_t;
  logic [127:0] inj_d;
  bit chk_en;

  // reference model state
  bit m_prio;
  bit m_tags[$];
  logic m_err, m_c_vin, m_a_vout, m_b_vout, m_a_tout, m_b_tout;
  logic [1:0] m_c_tin;
  logic [127:0] m_c_din, m_a_dout, m_b_dout;

  // last observation
  logic o_a_rdy, o_b_rdy, o_a_vout, o_b_vout, o_a_tout, o_c_vin, o_err;
  logic [1:0] o_c_tin;
  logic [127:0] o_a_dout;

  function automatic void chk_w(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  function automatic void chk_b(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endfunction

  function automatic void model_reset();
    core_beat_t z;
    z = '0;
    m_prio = 1'b0;
    m_tags.delete();
    m_err = 1'b0; m_c_vin = 1'b0; m_c_tin = '0; m_c_din = '0;
    m_a_vout = 1'b0; m_a_tout = 1'b0; m_a_dout = '0;
    m_b_vout = 1'b0; m_b_tout = 1'b0; m_b_dout = '0;
    pipe.delete();
    pipe.push_back(z);
    pipe.push_back(z);
    inj_v = 1'b0;
  endfunction

  task automatic step();
    core_beat_t cin, cout;
    logic ea, eb, ga, gb;
    bit owner;
    int occ;
    @(negedge clk);
    o_c_vin = bus.c_vin; o_c_tin = bus.c_tin;
    o_a_vout = bus.a_vout; o_a_tout = bus.a_tout; o_a_dout = bus.a_dout;
    o_b_vout = bus.b_vout; o_err = err;
    if (chk_en) begin
      chk_b("c_vin", bus.c_vin, m_c_vin);
      chk_w("c_tin", 128'(bus.c_tin), 128'(m_c_tin));
      chk_w("c_din", bus.c_din, m_c_din);
      chk_b("a_vout", bus.a_vout, m_a_vout);
      if (m_a_vout) chk_b("a_tout", bus.a_tout, m_a_tout);
      chk_w("a_dout", bus.a_dout, m_a_dout);
      chk_b("b_vout", bus.b_vout, m_b_vout);
      if (m_b_vout) chk_b("b_tout", bus.b_tout, m_b_tout);
      chk_w("b_dout", bus.b_dout, m_b_dout);
      chk_b("err", err, m_err);
    end
    cin = '0;
    if (core_on && bus.c_vin === 1'b1 && bus.c_tin[1] === 1'b0) begin
      cin.v = 1'b1;
      cin.t = bus.c_tin[0];
      cin.d = bus.c_din + 128'hAA;
    end
    cout = pipe.pop_front();
    pipe.push_back(cin);
    if (inj_v) begin
      cout.v = 1'b1; cout.t = inj_t; cout.d = inj_d;
      inj_v = 1'b0;
    end
    bus.c_vout = cout.v;
    bus.c_tout = cout.v & cout.t;
    bus.c_dout = cout.v ? cout.d : '0;
    rst_n = d_rst_n; crypto_ready = d_cr;
    bus.a_vin = d_a_vin; bus.a_tin = d_a_tin; bus.a_din = d_a_din;
    bus.b_vin = d_b_vin; bus.b_tin = d_b_tin; bus.b_din = d_b_din;
    #1;
    o_a_rdy = bus.a_rdy; o_b_rdy = bus.b_rdy;
    occ = m_tags.size();
    ea = d_rst_n & d_cr & d_a_vin & (d_a_tin[1] ? (occ == 0) : (occ < DEPTH));
    eb = d_rst_n & d_cr & d_b_vin & (d_b_tin[1] ? (occ == 0) : (occ < DEPTH));
    ga = ea & (!eb | (m_prio == 1'b0));
    gb = eb & !ga;
    chk_b("a_rdy", bus.a_rdy, ga);
    chk_b("b_rdy", bus.b_rdy, gb);
    if (!d_rst_n) begin
      model_reset();
    end else begin
      m_c_vin = ga | gb;
      if (ga) begin m_c_tin = d_a_tin; m_c_din = d_a_din; end
      else if (gb) begin m_c_tin = d_b_tin; m_c_din = d_b_din; end
      m_a_vout = 1'b0; m_a_tout = 1'b0; m_a_dout = '0;
      m_b_vout = 1'b0; m_b_tout = 1'b0; m_b_dout = '0;
      if (cout.v && occ == 0) m_err = 1'b1;
      if (cout.v && occ > 0) begin
        owner = m_tags.pop_front();
        if (!owner) begin m_a_vout = 1'b1; m_a_tout = cout.t; m_a_dout = cout.d; end
        else begin m_b_vout = 1'b1; m_b_tout = cout.t; m_b_dout = cout.d; end
      end
      if ((ga && !d_a_tin[1]) || (gb && !d_b_tin[1])) m_tags.push_back(gb);
      if (ga) m_prio = 1'b1;
      else if (gb) m_prio = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    d_a_vin = 1'b0; d_b_vin = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[13];
    bit seq[$];
    int cnt, wait_cnt;
    bit found;

    tbl[0]  = '{0, 1, 2'b00, 1, 2'b00, 0, 0};
    tbl[1]  = '{1, 1, 2'b00, 1, 2'b00, 1, 0};
    tbl[2]  = '{1, 1, 2'b00, 1, 2'b00, 0, 1};
    tbl[3]  = '{1, 1, 2'b10, 0, 2'b00, 0, 0};
    tbl[4]  = '{1, 1, 2'b10, 1, 2'b00, 0, 1};
    tbl[5]  = '{1, 1, 2'b10, 0, 2'b00, 0, 0};
    tbl[6]  = '{1, 1, 2'b10, 0, 2'b00, 0, 0};
    tbl[7]  = '{1, 1, 2'b10, 0, 2'b00, 0, 0};
    tbl[8]  = '{1, 1, 2'b10, 0, 2'b00, 1, 0};
    tbl[9]  = '{1, 1, 2'b00, 1, 2'b11, 0, 1};
    tbl[10] = '{1, 1, 2'b01, 1, 2'b00, 1, 0};
    tbl[11] = '{1, 1, 2'b11, 1, 2'b01, 0, 1};
    tbl[12] = '{1, 0, 2'b00, 0, 2'b00, 0, 0};

    rst_n = 1'b0; crypto_ready = 1'b0;
    bus.a_vin = 1'b0; bus.a_tin = '0; bus.a_din = '0;
    bus.b_vin = 1'b0; bus.b_tin = '0; bus.b_din = '0;
    bus.c_vout = 1'b0; bus.c_tout = 1'b0; bus.c_dout = '0;
    d_rst_n = 1'b0; d_cr = 1'b0;
    d_a_vin = 1'b0; d_a_tin = '0; d_a_din = '0;
    d_b_vin = 1'b0; d_b_tin = '0; d_b_din = '0;
    core_on = 1'b1; inj_t = 1'b0; inj_d = '0;
    model_reset();
    chk_en = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    d_rst_n = 1'b1;
    step();
    chk_b("rst_c_vin", o_c_vin, 1'b0);
    chk_w("rst_c_tin", 128'(o_c_tin), 128'd0);
    chk_b("rst_a_vout", o_a_vout, 1'b0);
    chk_b("rst_err", o_err, 1'b0);

    // grant table from reset state
    for (int i = 0; i < 13; i++) begin
      d_cr = tbl[i].cr;
      d_a_vin = tbl[i].av; d_a_tin = tbl[i].at; d_a_din = {$urandom, $urandom, $urandom, $urandom};
      d_b_vin = tbl[i].bv; d_b_tin = tbl[i].bt; d_b_din = {$urandom, $urandom, $urandom, $urandom};
      step();
      chk_b($sformatf("tbl%0d_a_rdy", i), o_a_rdy, tbl[i].ea);
      chk_b($sformatf("tbl%0d_b_rdy", i), o_b_rdy, tbl[i].eb);
    end
    idle(6);

    // contention: grants and result routing alternate A,B,A,B
    d_a_vin = 1'b1; d_a_tin = 2'b00; d_b_vin = 1'b1; d_b_tin = 2'b01;
    for (int i = 0; i < 4; i++) begin
      d_a_din = 128'(100 + i); d_b_din = 128'(200 + i);
      step();
      chk_w($sformatf("cont_grant%0d", i), 128'({o_a_rdy, o_b_rdy}),
            (i % 2 == 0) ? 128'd2 : 128'd1);
    end
    d_a_vin = 1'b0; d_b_vin = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (o_a_vout === 1'b1) seq.push_back(1'b0);
      if (o_b_vout === 1'b1) seq.push_back(1'b1);
    end
    chk_w("cont_results", 128'(seq.size()), 128'd4);
    for (int i = 0; i < 4 && i < seq.size(); i++)
      chk_b($sformatf("cont_owner%0d", i), seq[i], (i % 2 == 1));

    // single ENC from A
    d_a_vin = 1'b1; d_a_tin = 2'b00; d_a_din = 128'h1;
    step();
    chk_b("single_acc", o_a_rdy, 1'b1);
    d_a_vin = 1'b0;
    step();
    chk_b("single_c_vin", o_c_vin, 1'b1);
    chk_w("single_c_tin", 128'(o_c_tin), 128'd0);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step();
      if (o_a_vout === 1'b1) begin
        found = 1'b1;
        chk_w("single_a_dout", o_a_dout, 128'hAB);
        chk_b("single_a_tout", o_a_tout, 1'b0);
      end
      chk_b("single_b_vout", o_b_vout, 1'b0);
    end
    chk_b("single_found", found, 1'b1);
    idle(4);

    // IV drain: three B beats outstanding, A's IV waits for the third result
    d_b_vin = 1'b1; d_b_tin = 2'b00;
    for (int i = 0; i < 3; i++) begin
      d_b_din = 128'(300 + i);
      step();
    end
    d_b_vin = 1'b0;
    d_a_vin = 1'b1; d_a_tin = 2'b11; d_a_din = 128'h1F;
    wait_cnt = 0; cnt = 0; found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (o_b_vout === 1'b1) cnt++;
      if (o_a_rdy === 1'b1) found = 1'b1;
      else wait_cnt++;
    end
    chk_b("iv_accepted", found, 1'b1);
    chk_w("iv_wait_cycles", 128'(wait_cnt), 128'd3);
    chk_w("iv_results_before", 128'(cnt), 128'd3);
    d_a_tin = 2'b10; d_a_din = 128'h2E;
    step();
    chk_b("iv_c_vin", o_c_vin, 1'b1);
    chk_w("iv_c_tin", 128'(o_c_tin), 128'd3);
    chk_b("key_after_iv_rdy", o_a_rdy, 1'b1);
    idle(6);

    // credit limit: core silent, B streams ENC
    core_on = 1'b0;
    d_b_vin = 1'b1; d_b_tin = 2'b00;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      d_b_din = 128'(400 + i);
      step();
      if (o_b_rdy === 1'b1) cnt++;
    end
    chk_w("credit_accepts", 128'(cnt), 128'(DEPTH));
    chk_b("credit_full_rdy", o_b_rdy, 1'b0);
    inj_v = 1'b1; inj_t = 1'b0; inj_d = 128'hC0FFEE;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (o_b_rdy === 1'b1) cnt++;
    end
    chk_w("credit_reopen", 128'(cnt), 128'd1);
    d_b_vin = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      inj_v = 1'b1; inj_t = 1'b1; inj_d = 128'(500 + i);
      step();
    end
    core_on = 1'b1;
    idle(3);

    // orphan response
    inj_v = 1'b1; inj_t = 1'b0; inj_d = 128'hDEAD;
    step();
    step();
    chk_b("orphan_err", o_err, 1'b1);
    chk_b("orphan_a_vout", o_a_vout, 1'b0);
    chk_b("orphan_b_vout", o_b_vout, 1'b0);
    idle(3);
    chk_b("orphan_err_held", o_err, 1'b1);

    // readiness gating, then reset with beats outstanding
    d_cr = 1'b0; d_a_vin = 1'b1; d_a_tin = 2'b00; d_a_din = 128'h77;
    step();
    chk_b("gate_rdy_low", o_a_rdy, 1'b0);
    d_cr = 1'b1;
    step();
    chk_b("gate_accept", o_a_rdy, 1'b1);
    d_a_din = 128'h78;
    step();
    d_a_vin = 1'b0; d_rst_n = 1'b0;
    step();
    d_rst_n = 1'b1;
    d_a_vin = 1'b1; d_a_tin = 2'b00; d_a_din = 128'h90;
    d_b_vin = 1'b1; d_b_tin = 2'b00; d_b_din = 128'h91;
    step();
    chk_b("mid_rst_c_vin", o_c_vin, 1'b0);
    chk_w("mid_rst_c_tin", 128'(o_c_tin), 128'd0);
    chk_b("mid_rst_err", o_err, 1'b0);
    chk_b("mid_rst_a_vout", o_a_vout, 1'b0);
    chk_b("mid_rst_prio_a", o_a_rdy, 1'b1);
    chk_b("mid_rst_prio_b", o_b_rdy, 1'b0);
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
